cpu_irq_timer: RTL
==================

// Module: cpu_irq_timer
// PURPOSE
//  Memory-mapped interval timer and interrupt aggregator on the cpu6502 bus; drives the CPU irq/nmi inputs.
//  Snoops addr/odata/rw; returns read data via rdata/rd_hit to the system read mux ahead of CPU idata.
//  Runs on clk4x; uses the CPU clk2 phase output as a bus-cycle strobe.
// PARAMETERS
//  BASE      16'h4000  base address; 8 registers at BASE..BASE+7, full 16-bit decode
//  PRESCALE  4         CPU cycles per timer tick (1..256); CTRL.ps=0 bypasses it (1 tick/cycle)
//  NEXT      4         number of external IRQ sources
// PORTS
//  clk4x    in   1     sole clock; all flops on posedge
//  reset    in   1     synchronous, active-high
//  clk2     in   1     CPU phase-2 clock, sampled as data; bus cycle ends on sampled 1->0
//  addr     in   16    CPU address
//  odata    in   8     CPU write data
//  rw       in   1     1=read, 0=write
//  ext_irq  in   NEXT  level IRQ requests, active-high, synchronous to clk4x
//  ext_nmi  in   1     NMI request, rising-edge sensitive
//  rdata    out  8     register read data (combinational from addr + registers)
//  rd_hit   out  1     addr in BASE..BASE+7 and rw=1
//  irq      out  1     active-high level IRQ to CPU
//  nmi      out  1     active-high NMI pulse to CPU
// BEHAVIOUR
//  Reset: all registers 0, counter 0, flags 0, irq=0, nmi=0, rd_hit follows addr/rw, prescaler 0.
//  cyc_end = clk2_q & ~clk2 (registered previous-sample compare); 1 clk4x pulse per CPU cycle.
//  Writes commit on cyc_end when rw=0 and addr hits; no effect mid-cycle.
//  Register map (offset):
//   0 CTRL   rw [0]en [1]reload [2]tie [3]ps; other bits read 0
//   1 STAT   r:[0]tflag [1]extany ; w: bit0=1 clears tflag (W1C), bit1 ignored
//   2 RLD_LO rw low reload byte
//   3 RLD_HI rw high reload byte; write also loads counter = {odata,RLD_LO}, clears prescaler
//   4 CNT_LO r counter[7:0]; read (cyc_end, rw=1) latches counter[15:8] into cnt_hi_lat
//   5 CNT_HI r cnt_hi_lat (coherent 16-bit read: LO then HI)
//   6 MASK   rw [NEXT-1:0] ext enable mask
//   7 PEND   r ext_irq & MASK (live); writes ignored
//  Tick: on cyc_end with en=1, prescaler counts 0..PRESCALE-1; tick at wrap (ps=1) or every cyc_end (ps=0).
//  On tick: counter!=0 -> counter-1. counter==1 -> goes 0, tflag<=1, then if reload counter<=RELOAD
//   on the next tick (0 held for exactly one tick); if !reload counter stays 0, en unchanged.
//  counter==0 on tick with reload=1 -> load RELOAD; with reload=0 -> stay 0, no new flag.
//  Simultaneous: RLD_HI write beats tick decrement same cycle; tflag set beats W1C clear same cycle.
//  irq = (tflag & tie) | |(ext_irq & MASK); registered, 1 clk4x latency from cause.
//  nmi: ext_nmi rising edge (registered detect) loads a 3-bit timer with 4; nmi=1 while timer!=0,
//   decremented on each cyc_end; new edge during pulse reloads to 4 (pulse extended).
//  Reset mid-pulse or mid-count: everything returns to reset values next edge; no pending state survives.
//  Counter arithmetic 16-bit unsigned, never underflows past 0.
// STRUCTURE
//  Shared package/header cpu_bus_defs: register offsets, CTRL/STAT bit indices, BASE default.
//  One sub-module natural: bus_cycle_strobe (clk2 sampler -> cyc_end); rest in this file.
// TESTING
//  Reset: hold reset 3 cycles -> irq=0, nmi=0, reads of offsets 0..7 return 0.
//  Write RLD_LO=03,RLD_HI=00,CTRL=07 (ps=0) -> tflag+irq after 3 cyc_end; 1 tick at 0; reload 3.
//  ps=1, PRESCALE=4, count 2 -> tflag after exactly 8 cyc_end; STAT write 01 -> irq drops next clk.
//  Counter 0x0100 counting: read CNT_LO=00 then HI across a tick -> HI=01 (latched), not 00.
//  ext_irq=0b0101, MASK=0b0100 -> irq=1, PEND=04; MASK=0 -> irq=0 one clk4x later.
//  ext_nmi rising edge -> nmi high for 4 cyc_end; second edge at cycle 2 -> high 6 total.

Source files
------------

// File: rtl/cpu_irq_timer_pkg.sv
// Shared bus definitions for the cpu6502 interval timer / interrupt block:
// register offsets, CTRL/STAT bit positions and the default base address.
package cpu_irq_timer_pkg;

    localparam logic [15:0] BASE_DEFAULT = 16'h4000;

    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_STAT   = 3'd1;
    localparam logic [2:0] OFF_RLD_LO = 3'd2;
    localparam logic [2:0] OFF_RLD_HI = 3'd3;
    localparam logic [2:0] OFF_CNT_LO = 3'd4;
    localparam logic [2:0] OFF_CNT_HI = 3'd5;
    localparam logic [2:0] OFF_MASK   = 3'd6;
    localparam logic [2:0] OFF_PEND   = 3'd7;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_RELOAD = 1;
    localparam int CTRL_TIE    = 2;
    localparam int CTRL_PS     = 3;

    localparam int STAT_TFLAG  = 0;
    localparam int STAT_EXTANY = 1;

    localparam logic [2:0] NMI_PULSE_CYCLES = 3'd4;

endpackage

// File: rtl/cpu_irq_timer_bus_cycle_strobe.sv
// Turns the sampled CPU phase-2 clock into a one-clk4x strobe at the end of
// every bus cycle (falling edge of clk2 as seen by clk4x).
module cpu_irq_timer_bus_cycle_strobe
    import cpu_irq_timer_pkg::*;
(
    input  logic clk4x,
    input  logic reset,
    input  logic clk2,
    output logic cyc_end
);

    logic clk2_q;

    always_ff @(posedge clk4x) begin
        if (reset) begin
            clk2_q <= 1'b0;
        end else begin
            clk2_q <= clk2;
        end
    end

    assign cyc_end = clk2_q & ~clk2;

endmodule

// File: rtl/cpu_irq_timer.sv
// Memory-mapped 16-bit interval timer plus IRQ/NMI aggregator for the cpu6502
// bus. Snoops the CPU bus; register writes commit only at the end of a cycle.
module cpu_irq_timer
    import cpu_irq_timer_pkg::*;
#(
    parameter logic [15:0] BASE     = BASE_DEFAULT,
    parameter int          PRESCALE = 4,
    parameter int          NEXT     = 4
) (
    input  logic            clk4x,
    input  logic            reset,
    input  logic            clk2,
    input  logic [15:0]     addr,
    input  logic [7:0]      odata,
    input  logic            rw,
    input  logic [NEXT-1:0] ext_irq,
    input  logic            ext_nmi,
    output logic [7:0]      rdata,
    output logic            rd_hit,
    output logic            irq,
    output logic            nmi
);

    localparam logic [7:0] PS_LAST = 8'(PRESCALE - 1);

    logic            cyc_end;
    logic [15:0]     off_full;
    logic            hit;
    logic [2:0]      off;
    logic            wr_en;
    logic            rd_en;

    logic [3:0]      ctrl;
    logic            tflag;
    logic [15:0]     rld;
    logic [15:0]     counter;
    logic [7:0]      cnt_hi_lat;
    logic [NEXT-1:0] mask;
    logic [7:0]      presc;
    logic            ext_nmi_q;
    logic [2:0]      nmi_tmr;

    logic [NEXT-1:0] pend;
    logic            extany;
    logic            tick_en;
    logic            ps_wrap;
    logic            tick;
    logic            wr_rld_hi;

    cpu_irq_timer_bus_cycle_strobe u_strobe (
        .clk4x   (clk4x),
        .reset   (reset),
        .clk2    (clk2),
        .cyc_end (cyc_end)
    );

    // Full 16-bit decode via offset subtraction, so BASE need not be 8-aligned.
    assign off_full  = addr - BASE;
    assign hit       = (off_full[15:3] == 13'd0);
    assign off       = off_full[2:0];
    assign rd_hit    = hit & rw;
    assign wr_en     = cyc_end & ~rw & hit;
    assign rd_en     = cyc_end & rw & hit;
    assign wr_rld_hi = wr_en & (off == OFF_RLD_HI);

    assign pend    = ext_irq & mask;
    assign extany  = |pend;
    assign tick_en = cyc_end & ctrl[CTRL_EN];
    assign ps_wrap = (presc == PS_LAST);
    assign tick    = tick_en & (~ctrl[CTRL_PS] | ps_wrap);

    always_comb begin
        rdata = 8'h00;
        if (hit) begin
            case (off)
                OFF_CTRL:   rdata = {4'h0, ctrl};
                OFF_STAT:   rdata = {6'h00, extany, tflag};
                OFF_RLD_LO: rdata = rld[7:0];
                OFF_RLD_HI: rdata = rld[15:8];
                OFF_CNT_LO: rdata = counter[7:0];
                OFF_CNT_HI: rdata = cnt_hi_lat;
                OFF_MASK:   rdata = 8'(mask);
                OFF_PEND:   rdata = 8'(pend);
                default:    rdata = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk4x) begin
        if (reset) begin
            ctrl       <= 4'h0;
            rld        <= 16'h0000;
            mask       <= '0;
            cnt_hi_lat <= 8'h00;
        end else begin
            if (wr_en && off == OFF_CTRL)   ctrl      <= odata[3:0];
            if (wr_en && off == OFF_RLD_LO) rld[7:0]  <= odata;
            if (wr_rld_hi)                  rld[15:8] <= odata;
            if (wr_en && off == OFF_MASK)   mask      <= odata[NEXT-1:0];
            // Latch the high byte alongside the low-byte read for a coherent 16-bit read.
            if (rd_en && off == OFF_CNT_LO) cnt_hi_lat <= counter[15:8];
        end
    end

    always_ff @(posedge clk4x) begin
        if (reset) begin
            presc   <= 8'h00;
            counter <= 16'h0000;
            tflag   <= 1'b0;
        end else begin
            if (wr_rld_hi) begin
                presc <= 8'h00;
            end else if (tick_en && ctrl[CTRL_PS]) begin
                presc <= ps_wrap ? 8'h00 : presc + 8'd1;
            end

            // Reloading through RLD_HI takes priority over a tick in the same cycle.
            if (wr_rld_hi) begin
                counter <= {odata, rld[7:0]};
            end else if (tick) begin
                if (counter != 16'h0000) begin
                    counter <= counter - 16'd1;
                end else if (ctrl[CTRL_RELOAD]) begin
                    counter <= rld;
                end
            end

            if (!wr_rld_hi && tick && counter == 16'h0001) begin
                tflag <= 1'b1;
            end else if (wr_en && off == OFF_STAT && odata[STAT_TFLAG]) begin
                tflag <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk4x) begin
        if (reset) begin
            irq       <= 1'b0;
            ext_nmi_q <= 1'b0;
            nmi_tmr   <= 3'd0;
        end else begin
            irq       <= (tflag & ctrl[CTRL_TIE]) | extany;
            ext_nmi_q <= ext_nmi;
            if (ext_nmi && !ext_nmi_q) begin
                nmi_tmr <= NMI_PULSE_CYCLES;
            end else if (cyc_end && nmi_tmr != 3'd0) begin
                nmi_tmr <= nmi_tmr - 3'd1;
            end
        end
    end

    assign nmi = (nmi_tmr != 3'd0);

endmodule
